detector_stream_scheduler: RTL and testbench

Arbitrates two requesters for one shared serial sequence-detector `state_machine` (ports X, CLK, Y, RST) and sequences each transaction end to end. Each transaction follows the same steps:
- latch the granted requester's parallel word;
- pulse the detector reset;
- shift the word into X, MSB first, one bit per clock;
- count the cycles in which Y reports a detection;
- return the count with a one-cycle DONE strobe.

The block sits between the requesters and the detector instance.

---
 rtl/detector_stream_scheduler.sv | 101 ++++++++++
 tb/tb_detector_stream_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_stream_scheduler.sv
// rtl/detector_stream_scheduler.sv - two-requester round-robin sequencer for a shared serial sequence detector
module detector_stream_scheduler #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DATA0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA1,
    output logic [1:0]       GNT,
    output logic             DONE,
    output logic             DONE_ID,
    output logic [CNTW-1:0]  MATCH_CNT,
    output logic             BUSY,
    output logic             DET_X,
    output logic             DET_RST,
    input  logic             DET_Y
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, RESP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] word;
    logic [BW-1:0]    bit_idx;
    logic             lsp;
    logic             sent_d;
    logic [CNTW-1:0]  cnt;
    logic             grant;
    logic             winner;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant  = REQ0 | REQ1;
        winner = (REQ0 && REQ1) ? ~lsp : REQ1;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (grant) state_n = LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   if (bit_idx == LAST_BIT) state_n = DRAIN;
            DRAIN:   state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            word    <= '0;
            bit_idx <= '0;
            lsp     <= 1'b1;
            sent_d  <= 1'b0;
            cnt     <= '0;
            GNT     <= 2'b00;
            DONE    <= 1'b0;
            DONE_ID <= 1'b0;
            DET_X   <= 1'b0;
            DET_RST <= 1'b0;
        end else begin
            state   <= state_n;
            sent_d  <= (state == SHIFT);
            DET_RST <= (state_n == LOAD);
            DONE    <= (state_n == RESP);
            // Outputs are registered from the next state so DET_X lines up with SHIFT cycles.
            DET_X   <= (state_n == SHIFT) ? word[WIDTH-1] : 1'b0;

            if (state == IDLE && grant) begin
                word    <= winner ? DATA1 : DATA0;
                lsp     <= winner;
                DONE_ID <= winner;
                GNT     <= winner ? 2'b10 : 2'b01;
            end else if (state == LOAD || state == SHIFT) begin
                word <= {word[WIDTH-2:0], 1'b0};
            end else if (state == RESP) begin
                GNT <= 2'b00;
            end

            if (state == SHIFT)
                bit_idx <= bit_idx + BW'(1);
            else
                bit_idx <= '0;

            // Y lags X by one clock, so sample in the cycle after each SHIFT cycle.
            if (state == LOAD)
                cnt <= '0;
            else if (sent_d && DET_Y && cnt != {CNTW{1'b1}})
                cnt <= cnt + CNTW'(1);
        end
    end

    assign MATCH_CNT = cnt;
    assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_detector_stream_scheduler.sv
// tb/tb_detector_stream_scheduler.sv - randomized self-checking bench for detector_stream_scheduler
module tb_detector_stream_scheduler;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] data0 = '0, data1 = '0;
    logic [1:0]  gnt;
    logic        done, done_id, busy, det_x, det_rst, det_y;
    logic [4:0]  match_cnt;
    logic        echo_y = 1'b0;
    logic        rand_mode = 1'b0, rand_y = 1'b0;

    logic        req0_b = 1'b0, req1_b = 1'b0;
    logic [15:0] data0_b = '0, data1_b = '0;
    logic [1:0]  gnt_b;
    logic        done_b, done_id_b, busy_b, det_x_b, det_rst_b, det_y_b;
    logic [2:0]  match_cnt_b;
    logic        echo_b = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit lsp_m   = 1'b1;
    int last_cnt_m = 0;

    int          o_timeout, o_load_cyc, o_done_cyc, o_done_n, o_id, o_cnt;
    logic [1:0]  o_gnt, o_gnt_after;
    logic [15:0] o_xseq;
    logic [19:0] o_rst_mask;
    bit          o_x_out, o_busy_ok, o_busy_after;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Detector stand-ins: Y is X delayed one clock, cleared by the detector reset.
    always @(posedge clk) echo_y <= det_rst ? 1'b0 : det_x;
    always @(posedge clk) echo_b <= det_rst_b ? 1'b0 : det_x_b;
    assign det_y   = rand_mode ? rand_y : echo_y;
    assign det_y_b = echo_b;

    detector_stream_scheduler #(.WIDTH(16), .CNTW(5)) dut (
        .CLK(clk), .RST(rst), .REQ0(req0), .DATA0(data0), .REQ1(req1), .DATA1(data1),
        .GNT(gnt), .DONE(done), .DONE_ID(done_id), .MATCH_CNT(match_cnt), .BUSY(busy),
        .DET_X(det_x), .DET_RST(det_rst), .DET_Y(det_y)
    );

    detector_stream_scheduler #(.WIDTH(16), .CNTW(3)) dut3 (
        .CLK(clk), .RST(rst), .REQ0(req0_b), .DATA0(data0_b), .REQ1(req1_b), .DATA1(data1_b),
        .GNT(gnt_b), .DONE(done_b), .DONE_ID(done_id_b), .MATCH_CNT(match_cnt_b), .BUSY(busy_b),
        .DET_X(det_x_b), .DET_RST(det_rst_b), .DET_Y(det_y_b)
    );

    function automatic int ref_count(input logic [15:0] w, input int cw);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(w[i]);
        if (n > (1 << cw) - 1) n = (1 << cw) - 1;
        return n;
    endfunction

    function automatic bit ref_winner(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    function automatic logic [1:0] f_gnt(input bit sel);  return sel ? gnt_b : gnt; endfunction
    function automatic logic f_x(input bit sel);          return sel ? det_x_b : det_x; endfunction
    function automatic logic f_rst(input bit sel);        return sel ? det_rst_b : det_rst; endfunction
    function automatic logic f_busy(input bit sel);       return sel ? busy_b : busy; endfunction
    function automatic logic f_done(input bit sel);       return sel ? done_b : done; endfunction
    function automatic int   f_id(input bit sel);         return sel ? int'(done_id_b) : int'(done_id); endfunction
    function automatic int   f_cnt(input bit sel);        return sel ? int'(match_cnt_b) : int'(match_cnt); endfunction

    // Records one transaction cycle by cycle, cycle 1 being LOAD; ends on the IDLE cycle after RESP.
    task automatic observe(input bit sel, input bit release_reqs, input bit new_data,
                           input logic [15:0] nd0, input logic [15:0] nd1);
        int waited = 0;
        o_timeout = 0; o_xseq = '0; o_rst_mask = '0; o_x_out = 0; o_done_cyc = -1;
        o_done_n = 0; o_id = -1; o_cnt = -1; o_busy_ok = 1; o_gnt = 2'b00;
        o_busy_after = 1; o_gnt_after = 2'b11; o_load_cyc = -1;
        @(negedge clk);
        while (f_gnt(sel) == 2'b00 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (f_gnt(sel) == 2'b00) begin
            o_timeout = 1;
            return;
        end
        o_load_cyc = cyc;
        o_gnt = f_gnt(sel);
        if (release_reqs) begin req0 = 0; req1 = 0; req0_b = 0; req1_b = 0; end
        if (new_data) begin
            if (sel) begin data0_b = nd0; data1_b = nd1; end
            else begin data0 = nd0; data1 = nd1; end
        end
        for (int c = 1; c <= W + 3; c++) begin
            if (c > 1) @(negedge clk);
            if (f_rst(sel)) o_rst_mask[c] = 1'b1;
            if (c >= 2 && c <= W + 1) o_xseq[W + 1 - c] = f_x(sel);
            else if (f_x(sel)) o_x_out = 1;
            if (!f_busy(sel) || f_gnt(sel) !== o_gnt) o_busy_ok = 0;
            if (f_done(sel)) begin
                o_done_n++;
                if (o_done_cyc < 0) begin
                    o_done_cyc = c;
                    o_id = f_id(sel);
                    o_cnt = f_cnt(sel);
                end
            end
        end
        @(negedge clk);
        o_busy_after = f_busy(sel);
        o_gnt_after  = f_gnt(sel);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({gnt, done, done_id, match_cnt, busy, det_x, det_rst} !== 12'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {gnt, done, done_id, match_cnt, busy, det_x, det_rst});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({gnt, done, busy, det_x, det_rst, match_cnt} !== 10'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 0", {gnt, done, busy, det_x, det_rst, match_cnt});
        end
    endtask

    task automatic test_single();
        bit w;
        int exp_cnt;
        data0 = 16'hF00F; req0 = 1;
        w = ref_winner(1, 0, lsp_m); lsp_m = w;
        exp_cnt = ref_count(16'hF00F, 5); last_cnt_m = exp_cnt;
        observe(0, 1, 0, '0, '0);
        vectors++;
        if (o_timeout != 0) begin errors++; $display("FAIL single_grant: got timeout=%0d want 0", o_timeout); end
        vectors++;
        if (o_xseq !== 16'hF00F) begin errors++; $display("FAIL single_xseq: got %b want %b", o_xseq, 16'hF00F); end
        vectors++;
        if (o_done_cyc != W + 3 || o_done_n != 1) begin
            errors++; $display("FAIL single_done: got cycle %0d count %0d want cycle %0d count 1", o_done_cyc, o_done_n, W + 3);
        end
        vectors++;
        if (o_id != int'(w) || o_cnt != exp_cnt) begin
            errors++; $display("FAIL single_result: got id %0d cnt %0d want id %0d cnt %0d", o_id, o_cnt, w, exp_cnt);
        end
        vectors++;
        if (o_rst_mask !== 20'd2 || o_x_out) begin
            errors++; $display("FAIL single_detrst: got rst mask %b xout %0d want %b xout 0", o_rst_mask, o_x_out, 20'd2);
        end
        vectors++;
        if (!o_busy_ok || o_gnt !== 2'b01 || o_busy_after || o_gnt_after !== 2'b00) begin
            errors++; $display("FAIL single_gnt_busy: got gnt %b ok %0d after %0d/%b want 01 1 0/00", o_gnt, o_busy_ok, o_busy_after, o_gnt_after);
        end
    endtask

    task automatic test_round_robin();
        int prev = -1;
        bit w;
        int exp_cnt;
        data0 = 16'h0001; data1 = 16'h00FF; req0 = 1; req1 = 1;
        for (int t = 0; t < 4; t++) begin
            w = ref_winner(1, 1, lsp_m); lsp_m = w;
            exp_cnt = ref_count(w ? 16'h00FF : 16'h0001, 5); last_cnt_m = exp_cnt;
            observe(0, 0, 0, '0, '0);
            vectors++;
            if (o_timeout != 0 || o_id != int'(w) || o_cnt != exp_cnt || o_xseq !== (w ? 16'h00FF : 16'h0001)) begin
                errors++;
                $display("FAIL rr_txn%0d: got to %0d id %0d cnt %0d x %h want to 0 id %0d cnt %0d", t, o_timeout, o_id, o_cnt, o_xseq, w, exp_cnt);
            end
            if (prev >= 0) begin
                vectors++;
                if (o_load_cyc - prev != W + 4) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d want %0d", t, o_load_cyc - prev, W + 4);
                end
            end
            prev = o_load_cyc;
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_saturate();
        int exp_cnt;
        data1_b = 16'hFFFF; req1_b = 1;
        exp_cnt = ref_count(16'hFFFF, 3);
        observe(1, 1, 0, '0, '0);
        vectors++;
        if (o_timeout != 0 || o_cnt != exp_cnt || o_id != 1) begin
            errors++; $display("FAIL saturate: got to %0d cnt %0d id %0d want to 0 cnt %0d id 1", o_timeout, o_cnt, o_id, exp_cnt);
        end
    endtask

    task automatic test_pulse();
        bit w;
        int exp_cnt;
        bit quiet = 1;
        data0 = 16'hAAAA; req0 = 1;
        w = ref_winner(1, 0, lsp_m); lsp_m = w;
        exp_cnt = ref_count(16'hAAAA, 5); last_cnt_m = exp_cnt;
        observe(0, 1, 1, 16'h0000, 16'h0000);
        vectors++;
        if (o_timeout != 0 || o_cnt != exp_cnt || o_id != int'(w) || o_done_n != 1) begin
            errors++; $display("FAIL pulse_txn: got to %0d cnt %0d id %0d dones %0d want to 0 cnt %0d id %0d dones 1", o_timeout, o_cnt, o_id, o_done_n, exp_cnt, w);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00 || busy !== 1'b0) quiet = 0;
        end
        vectors++;
        if (!quiet) begin errors++; $display("FAIL pulse_no_regrant: got quiet=%0d want 1", quiet); end
    endtask

    task automatic test_random();
        bit w, r0, r1;
        int rq, exp_cnt;
        logic [15:0] d0, d1, exp_word;
        for (int t = 0; t < 8; t++) begin
            rq = $urandom_range(1, 3);
            r0 = rq[0]; r1 = rq[1];
            d0 = 16'($urandom); d1 = 16'($urandom);
            data0 = d0; data1 = d1; req0 = r0; req1 = r1;
            w = ref_winner(r0, r1, lsp_m); lsp_m = w;
            exp_word = w ? d1 : d0;
            exp_cnt = ref_count(exp_word, 5); last_cnt_m = exp_cnt;
            observe(0, 1, 1, 16'($urandom), 16'($urandom));
            vectors++;
            if (o_timeout != 0 || o_id != int'(w) || o_cnt != exp_cnt || o_xseq !== exp_word ||
                o_done_cyc != W + 3 || o_rst_mask !== 20'd2 || o_x_out || o_gnt !== (w ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL random%0d: got id %0d cnt %0d x %h done@%0d gnt %b want id %0d cnt %0d x %h done@%0d gnt %b",
                         t, o_id, o_cnt, o_xseq, o_done_cyc, o_gnt, w, exp_cnt, exp_word, W + 3, w ? 2'b10 : 2'b01);
            end
        end
    endtask

    task automatic test_idle();
        bit ok = 1;
        rand_mode = 1;
        for (int i = 0; i < 30; i++) begin
            rand_y = 1'($urandom);
            @(negedge clk);
            if ({busy, det_x, det_rst} !== 3'b000 || int'(match_cnt) != last_cnt_m) ok = 0;
        end
        rand_mode = 0;
        vectors++;
        if (!ok) begin
            errors++; $display("FAIL idle_random_y: got busy %0d x %0d rst %0d cnt %0d want 0 0 0 %0d", busy, det_x, det_rst, match_cnt, last_cnt_m);
        end
    endtask

    task automatic test_reset_midway();
        int waited = 0;
        int dones = 0;
        bit w;
        int exp_cnt;
        logic [15:0] d0, d1;
        data0 = 16'h7FFF; req0 = 1;
        @(negedge clk);
        while (gnt == 2'b00 && waited < 50) begin @(negedge clk); waited++; end
        vectors++;
        if (gnt === 2'b00) begin errors++; $display("FAIL midway_grant: got gnt %b want nonzero", gnt); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({gnt, done, done_id, match_cnt, busy, det_x, det_rst} !== 12'b0) begin
            errors++;
            $display("FAIL midway_async_reset: got %b want 0", {gnt, done, done_id, match_cnt, busy, det_x, det_rst});
        end
        req0 = 0;
        lsp_m = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        vectors++;
        if (dones != 0) begin errors++; $display("FAIL midway_no_done: got %0d want 0", dones); end
        d0 = 16'($urandom); d1 = 16'($urandom);
        data0 = d0; data1 = d1; req0 = 1; req1 = 1;
        w = ref_winner(1, 1, lsp_m); lsp_m = w;
        exp_cnt = ref_count(w ? d1 : d0, 5); last_cnt_m = exp_cnt;
        observe(0, 1, 0, '0, '0);
        vectors++;
        if (o_timeout != 0 || o_id != int'(w) || o_cnt != exp_cnt) begin
            errors++; $display("FAIL midway_recover: got to %0d id %0d cnt %0d want to 0 id %0d cnt %0d", o_timeout, o_id, o_cnt, w, exp_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_saturate();
        test_pulse();
        test_random();
        test_idle();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
